// File: rtl/ahb_mtx_pkg.sv
// Shared AHB encodings and default-slave FSM state type for the bus-matrix
// input-port decoder.
package ahb_mtx_pkg;

    localparam int unsigned ADDR_W = 22;   // decoded HADDR[31:10]
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DFT_IDLE = 2'd0,
        DFT_ERR1 = 2'd1,
        DFT_ERR2 = 2'd2
    } dft_state_e;

endpackage

// File: rtl/ahb_mtx_dft_slave.sv
// Default slave for unmapped accesses: answers NONSEQ/SEQ with a two-cycle
// AHB ERROR response, IDLE/BUSY with zero-wait OKAY.
// Ports:
//   HCLK, HRESET   clock, synchronous active-high reset
//   hsel           default slave addressed by the input stage
//   htrans         HTRANS of the address phase
//   hready         input-stage HREADY (address phase accepted)
//   hreadyout      registered HREADYOUT
//   hresp          registered HRESP
//   err_pulse_c    high in the cycle whose edge enters ERR1
module ahb_mtx_dft_slave
    import ahb_mtx_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       hsel,
    input  logic [1:0] htrans,
    input  logic       hready,
    output logic       hreadyout,
    output logic [1:0] hresp,
    output logic       err_pulse_c
);

    dft_state_e state_d, state_q;
    logic       hreadyout_d, hreadyout_q;
    logic [1:0] hresp_d, hresp_q;
    logic       start_c;

    // A qualifying access is an accepted NONSEQ/SEQ transfer to this slave.
    assign start_c = hsel & hready &
                     ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        err_pulse_c = 1'b0;
        case (state_q)
            DFT_IDLE: if (start_c) state_d = DFT_ERR1;
            DFT_ERR1: state_d = DFT_ERR2;
            DFT_ERR2: state_d = start_c ? DFT_ERR1 : DFT_IDLE;
            default:  state_d = DFT_IDLE;
        endcase
        if (state_d == DFT_ERR1) begin
            hreadyout_d = 1'b0;
            err_pulse_c = 1'b1;      // ERR1 lasts one cycle, so every entry is a new error
        end
        if (state_d != DFT_IDLE) hresp_d = HRESP_ERROR;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= DFT_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;

endmodule

// File: rtl/ahb_mtx_param_decoder.sv
// AHB bus-matrix input-port decoder: selects one of NUM_PORTS output stages
// (or the built-in default slave) from HADDR[31:10], tracks the data phase
// and returns ready/resp/rdata/ruser from the selected stage.
// Ports:
//   HCLK, HRESET     clock, synchronous active-high reset
//   HREADYS          input-stage HREADY
//   sel_dec          input-stage HSEL
//   decode_addr_dec  HADDR[31:10]
//   trans_dec        HTRANS
//   active_in        per-port active flags
//   readyout_in      per-port HREADYOUT
//   resp_in          per-port HRESP, port i at [2*i +: 2]
//   rdata_in         per-port HRDATA, port i at [32*i +: 32]
//   ruser_in         per-port HRUSER, port i at [32*i +: 32]
//   err_clr          clears err_count (wins over increment)
//   sel_out          one-hot HSEL to the output stages
//   active_dec       active flag of the addressed port
//   HREADYOUTS       HREADY feedback
//   HRESPS           HRESP feedback
//   HRDATAS          read data
//   HRUSERS          user read data
//   err_count        saturating count of ERROR responses issued
module ahb_mtx_param_decoder
    import ahb_mtx_pkg::*;
#(
    parameter int unsigned                      NUM_PORTS    = 4,
    parameter logic [ADDR_W*NUM_PORTS-1:0]      REGION_BASE  = {NUM_PORTS{22'h0}},
    parameter logic [ADDR_W*NUM_PORTS-1:0]      REGION_LIMIT = {NUM_PORTS{22'h0}},
    parameter int unsigned                      ERRCNT_W     = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          HREADYS,
    input  logic                          sel_dec,
    input  logic [ADDR_W-1:0]             decode_addr_dec,
    input  logic [1:0]                    trans_dec,
    input  logic [NUM_PORTS-1:0]          active_in,
    input  logic [NUM_PORTS-1:0]          readyout_in,
    input  logic [2*NUM_PORTS-1:0]        resp_in,
    input  logic [DATA_W*NUM_PORTS-1:0]   rdata_in,
    input  logic [DATA_W*NUM_PORTS-1:0]   ruser_in,
    input  logic                          err_clr,
    output logic [NUM_PORTS-1:0]          sel_out,
    output logic                          active_dec,
    output logic                          HREADYOUTS,
    output logic [1:0]                    HRESPS,
    output logic [DATA_W-1:0]             HRDATAS,
    output logic [DATA_W-1:0]             HRUSERS,
    output logic [ERRCNT_W-1:0]           err_count
);

    logic [NUM_PORTS-1:0] hit_c;
    logic [NUM_PORTS:0]   addr_sel_c;
    logic [NUM_PORTS:0]   data_sel_d, data_sel_q;
    logic [ERRCNT_W-1:0]  err_cnt_d, err_cnt_q;
    logic                 dft_hsel_c;
    logic                 dft_ready;
    logic [1:0]           dft_resp;
    logic                 err_pulse_c;

    // Per-port inclusive region compare.
    for (genvar i = 0; i < int'(NUM_PORTS); i++) begin : g_region
        assign hit_c[i] = (decode_addr_dec >= REGION_BASE[ADDR_W*i +: ADDR_W]) &&
                          (decode_addr_dec <= REGION_LIMIT[ADDR_W*i +: ADDR_W]);
    end

    // Priority encode (lowest index wins), default slave on miss.
    always_comb begin
        addr_sel_c            = '0;
        addr_sel_c[NUM_PORTS] = 1'b1;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (hit_c[i]) begin
                addr_sel_c    = '0;
                addr_sel_c[i] = 1'b1;
            end
        end
        // IDLE cycles stay on the port that owns the current data phase.
        if ((trans_dec == HTRANS_IDLE) && (|data_sel_q[NUM_PORTS-1:0])) begin
            addr_sel_c = data_sel_q;
        end
    end

    assign sel_out    = sel_dec ? addr_sel_c[NUM_PORTS-1:0] : '0;
    assign active_dec = addr_sel_c[NUM_PORTS] | (|(addr_sel_c[NUM_PORTS-1:0] & active_in));
    assign dft_hsel_c = sel_dec & addr_sel_c[NUM_PORTS];

    ahb_mtx_dft_slave u_dft_slave (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .hsel        (dft_hsel_c),
        .htrans      (trans_dec),
        .hready      (HREADYS),
        .hreadyout   (dft_ready),
        .hresp       (dft_resp),
        .err_pulse_c (err_pulse_c)
    );

    // Data-phase owner and error counter next state.
    always_comb begin
        data_sel_d = HREADYS ? addr_sel_c : data_sel_q;
        err_cnt_d  = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (err_pulse_c && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            data_sel_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            data_sel_q <= data_sel_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Data-phase response mux; no owner gives an idle OKAY.
    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = HRESP_OKAY;
        HRDATAS    = '0;
        HRUSERS    = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (data_sel_q[i]) begin
                HREADYOUTS = readyout_in[i];
                HRESPS     = resp_in[2*i +: 2];
                HRDATAS    = rdata_in[DATA_W*i +: DATA_W];
                HRUSERS    = ruser_in[DATA_W*i +: DATA_W];
            end
        end
        if (data_sel_q[NUM_PORTS]) begin
            HREADYOUTS = dft_ready;
            HRESPS     = dft_resp;
        end
    end

    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_ahb_mtx_param_decoder.sv
// Directed bench for ahb_mtx_param_decoder (4 ports, 2-bit error counter).
module tb_ahb_mtx_param_decoder;
    import ahb_mtx_pkg::*;

    localparam int unsigned NP = 4;
    localparam logic [21:0] A_P0   = 22'h000100;
    localparam logic [21:0] A_P1   = 22'h001800;
    localparam logic [21:0] A_P2   = 22'h1000c0;
    localparam logic [21:0] A_OVL  = 22'h000900;
    localparam logic [21:0] A_UNM  = 22'h200000;

    typedef struct {
        logic [3:0]  sel;
        logic        act;
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] ruser;
        logic [1:0]  cnt;
    } exp_t;

    logic               HCLK = 1'b0;
    logic               HRESET = 1'b1;
    logic               HREADYS = 1'b1;
    logic               sel_dec = 1'b0;
    logic [21:0]        decode_addr_dec = A_UNM;
    logic [1:0]         trans_dec = HTRANS_NONSEQ;
    logic [NP-1:0]      active_in = 4'b1010;
    logic [NP-1:0]      readyout_in = 4'hF;
    logic [2*NP-1:0]    resp_in = '0;
    logic [32*NP-1:0]   rdata_in;
    logic [32*NP-1:0]   ruser_in;
    logic               err_clr = 1'b0;
    logic [NP-1:0]      sel_out;
    logic               active_dec;
    logic               HREADYOUTS;
    logic [1:0]         HRESPS;
    logic [31:0]        HRDATAS;
    logic [31:0]        HRUSERS;
    logic [1:0]         err_count;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    ahb_mtx_param_decoder #(
        .NUM_PORTS    (NP),
        .REGION_BASE  ({22'h000800, 22'h0100c0, 22'h001000, 22'h000000}),
        .REGION_LIMIT ({22'h000bff, 22'h1400bf, 22'h001fff, 22'h000fff}),
        .ERRCNT_W     (2)
    ) dut (
        .HCLK            (HCLK),
        .HRESET          (HRESET),
        .HREADYS         (HREADYS),
        .sel_dec         (sel_dec),
        .decode_addr_dec (decode_addr_dec),
        .trans_dec       (trans_dec),
        .active_in       (active_in),
        .readyout_in     (readyout_in),
        .resp_in         (resp_in),
        .rdata_in        (rdata_in),
        .ruser_in        (ruser_in),
        .err_clr         (err_clr),
        .sel_out         (sel_out),
        .active_dec      (active_dec),
        .HREADYOUTS      (HREADYOUTS),
        .HRESPS          (HRESPS),
        .HRDATAS         (HRDATAS),
        .HRUSERS         (HRUSERS),
        .err_count       (err_count)
    );

    always #5 HCLK = ~HCLK;

    // dp = data-phase port whose rdata/ruser should appear, -1 for zero.
    function automatic exp_t mk(input logic [3:0] s, input logic a, input logic r,
                                input logic [1:0] rs, input int dp, input int c);
        exp_t e;
        e.sel   = s;
        e.act   = a;
        e.rdy   = r;
        e.resp  = rs;
        e.rdata = (dp < 0) ? 32'h0 : 32'hD000_0000 + 32'(dp);
        e.ruser = (dp < 0) ? 32'h0 : 32'hE000_0000 + 32'(dp);
        e.cnt   = 2'(c);
        return e;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic chk(input string tag, input string nm,
                       input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, nm, obs, expv);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then compare shortly after.
    task automatic cyc(input logic s, input logic [21:0] a, input logic [1:0] t,
                       input logic hr, input logic clr, input logic rst,
                       input string tag, input exp_t e);
        exp_t g;
        @(negedge HCLK);
        sel_dec         = s;
        decode_addr_dec = a;
        trans_dec       = t;
        HREADYS         = hr;
        err_clr         = clr;
        HRESET          = rst;
        exp_q.push_back(e);
        #1;
        g = exp_q.pop_front();
        chk(tag, "sel_out",    32'(sel_out),    32'(g.sel));
        chk(tag, "active_dec", 32'(active_dec), 32'(g.act));
        chk(tag, "HREADYOUTS", 32'(HREADYOUTS), 32'(g.rdy));
        chk(tag, "HRESPS",     32'(HRESPS),     32'(g.resp));
        chk(tag, "HRDATAS",    HRDATAS,         g.rdata);
        chk(tag, "HRUSERS",    HRUSERS,         g.ruser);
        chk(tag, "err_count",  32'(err_count),  32'(g.cnt));
    endtask

    task automatic idle(input logic clr, input string tag, input exp_t e);
        cyc(1'b0, A_UNM, HTRANS_NONSEQ, 1'b1, clr, 1'b0, tag, e);
    endtask

    localparam logic [1:0] OK = HRESP_OKAY;
    localparam logic [1:0] ER = HRESP_ERROR;

    initial begin
        for (int i = 0; i < int'(NP); i++) begin
            rdata_in[32*i +: 32] = 32'hD000_0000 + 32'(i);
            ruser_in[32*i +: 32] = 32'hE000_0000 + 32'(i);
        end

        // Reset values
        cyc(1'b0, A_UNM, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b1, "reset0", mk(4'b0000, 1, 1, OK, -1, 0));
        cyc(1'b0, A_UNM, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b1, "reset1", mk(4'b0000, 1, 1, OK, -1, 0));
        idle(1'b0, "idle0", mk(4'b0000, 1, 1, OK, -1, 0));

        // Port 2 decode and one-cycle data-phase latency
        cyc(1'b1, A_P2, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0, "t1_addr", mk(4'b0100, 0, 1, OK, -1, 0));
        idle(1'b0, "t1_data",  mk(4'b0000, 1, 1, OK, 2, 0));
        idle(1'b0, "t1_after", mk(4'b0000, 1, 1, OK, -1, 0));

        // Unmapped NONSEQ -> two-cycle ERROR
        cyc(1'b1, A_UNM, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0, "t2_addr", mk(4'b0000, 1, 1, OK, -1, 0));
        cyc(1'b0, A_UNM, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b0, "t2_err1", mk(4'b0000, 1, 0, ER, -1, 1));
        idle(1'b0, "t2_err2", mk(4'b0000, 1, 1, ER, -1, 1));
        idle(1'b1, "t2_idle", mk(4'b0000, 1, 1, OK, -1, 1));

        // Back-to-back unmapped accesses, second issued in ERR2
        cyc(1'b1, A_UNM, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0, "t3_addr0", mk(4'b0000, 1, 1, OK, -1, 0));
        cyc(1'b0, A_UNM, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b0, "t3_err1a", mk(4'b0000, 1, 0, ER, -1, 1));
        cyc(1'b1, A_UNM, HTRANS_SEQ,    1'b1, 1'b0, 1'b0, "t3_addr1", mk(4'b0000, 1, 1, ER, -1, 1));
        cyc(1'b0, A_UNM, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b0, "t3_err1b", mk(4'b0000, 1, 0, ER, -1, 2));
        idle(1'b0, "t3_err2b", mk(4'b0000, 1, 1, ER, -1, 2));
        idle(1'b0, "t3_idle",  mk(4'b0000, 1, 1, OK, -1, 2));

        // Sticky select on IDLE after a port-1 data phase
        cyc(1'b1, A_P1,  HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0, "t4_addr",   mk(4'b0010, 1, 1, OK, -1, 2));
        cyc(1'b1, A_UNM, HTRANS_IDLE,   1'b1, 1'b0, 1'b0, "t4_sticky", mk(4'b0010, 1, 1, OK, 1, 2));
        idle(1'b0, "t4_noerr", mk(4'b0000, 1, 1, OK, 1, 2));
        idle(1'b0, "t4_after", mk(4'b0000, 1, 1, OK, -1, 2));

        // Overlapping ports 0 and 3, plain port-0 decode
        cyc(1'b1, A_OVL, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0, "t5_overlap", mk(4'b0001, 0, 1, OK, -1, 2));
        idle(1'b1, "t5_data", mk(4'b0000, 1, 1, OK, 0, 2));
        cyc(1'b1, A_P0,  HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0, "t5_p0", mk(4'b0001, 0, 1, OK, -1, 0));
        idle(1'b0, "t5_p0_data", mk(4'b0000, 1, 1, OK, 0, 0));

        // BUSY to the default slave is a zero-wait OKAY
        cyc(1'b1, A_UNM, HTRANS_BUSY, 1'b1, 1'b0, 1'b0, "busy_addr", mk(4'b0000, 1, 1, OK, -1, 0));
        idle(1'b0, "busy_okay", mk(4'b0000, 1, 1, OK, -1, 0));

        // Five errors saturate a 2-bit counter at 3
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, A_UNM, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0, "t6_addr",
                mk(4'b0000, 1, 1, (k == 0) ? OK : ER, -1, sat3(k)));
            cyc(1'b0, A_UNM, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b0, "t6_err1",
                mk(4'b0000, 1, 0, ER, -1, sat3(k + 1)));
        end
        idle(1'b0, "t6_err2", mk(4'b0000, 1, 1, ER, -1, 3));
        idle(1'b0, "t6_sat",  mk(4'b0000, 1, 1, OK, -1, 3));

        // Reset while in ERR1
        cyc(1'b1, A_UNM, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0, "t6_rst_addr", mk(4'b0000, 1, 1, OK, -1, 3));
        cyc(1'b0, A_UNM, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b1, "t6_rst_err1", mk(4'b0000, 1, 0, ER, -1, 3));
        idle(1'b0, "t6_post_rst", mk(4'b0000, 1, 1, OK, -1, 0));

        // Clear coinciding with an ERR1 entry
        cyc(1'b1, A_UNM, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0, "t6_clr_a",     mk(4'b0000, 1, 1, OK, -1, 0));
        cyc(1'b0, A_UNM, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b0, "t6_clr_err1a", mk(4'b0000, 1, 0, ER, -1, 1));
        cyc(1'b1, A_UNM, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, "t6_clr_entry", mk(4'b0000, 1, 1, ER, -1, 1));
        cyc(1'b0, A_UNM, HTRANS_NONSEQ, 1'b0, 1'b0, 1'b0, "t6_clr_err1b", mk(4'b0000, 1, 0, ER, -1, 0));
        idle(1'b0, "t6_clr_err2", mk(4'b0000, 1, 1, ER, -1, 0));
        idle(1'b0, "t6_end",      mk(4'b0000, 1, 1, OK, -1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
